ifu_prefetch: RTL and testbench
===============================

IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 Parameter RESET_PC, 32'h8000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, 4, maximum of FIFO entries plus in-flight requests (power of two, 2..16).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 mem_req_valid  out  1  fetch request valid.
REQ-006 mem_req_ready  in  1  memory accepts request.
REQ-007 mem_req_addr  out  32  fetch address.
REQ-008 mem_rsp_valid  in  1  instruction response valid; responses are in request order and are always accepted.
REQ-009 mem_rsp_data  in  32  instruction word.
REQ-010 out_valid  out  1  fetched instruction available to IDU.
REQ-011 out_ready  in  1  IDU accepts instruction.
REQ-012 out_pc  out  32  PC of the head instruction.
REQ-013 out_instr  out  32  head instruction word.
REQ-014 redirect  in  1  branch/jump taken; flush and refetch.
REQ-015 redirect_pc  in  32  new fetch address.
REQ-016 err  out  1  sticky protocol error: response received with no request in flight.

Function
REQ-017 fetch_pc SHALL drive mem_req_addr; a request is accepted when mem_req_valid && mem_req_ready.
REQ-018 mem_req_valid SHALL equal !rst && !redirect && (occupancy + inflight < DEPTH).
REQ-019 On each accepted request, fetch_pc SHALL advance by 4, wrapping modulo 2^32.
REQ-020 inflight SHALL increment on each accepted request and decrement on each response; both in one cycle leave it unchanged.
REQ-021 If drop_cnt > 0, a response SHALL be discarded and drop_cnt decremented; otherwise {rsp_pc, mem_rsp_data} SHALL be pushed and rsp_pc advanced by 4.
REQ-022 out_valid SHALL equal FIFO non-empty; FIFO pop on out_valid && out_ready; no empty bypass, so a response at cycle r SHALL appear on out_* at r+1 at the earliest.
REQ-023 Push and pop in one cycle SHALL keep occupancy constant; the credit rule of REQ-018 guarantees a push never hits a full FIFO.
REQ-024 On redirect: fetch_pc and rsp_pc <= redirect_pc; FIFO cleared; any same-cycle response discarded; a same-cycle pop is ignored; drop_cnt <= inflight minus (1 if mem_rsp_valid).
REQ-025 The first request to redirect_pc SHALL be presented in the cycle after redirect.
REQ-026 Back-to-back redirects SHALL each re-apply REQ-024; the last one wins.
REQ-027 mem_rsp_valid with inflight == 0 SHALL set err until reset, and the response SHALL be ignored.
REQ-028 Counters (occupancy, inflight, drop_cnt) SHALL be $clog2(DEPTH)+1 bits wide and SHALL never exceed DEPTH.

Reset
REQ-029 During rst: fetch_pc and rsp_pc <= RESET_PC; FIFO empty; inflight, drop_cnt and err <= 0; mem_req_valid and out_valid are 0.
REQ-030 The first request to RESET_PC SHALL be presented in the first cycle after rst deasserts.
REQ-031 Reset mid-operation SHALL discard all state; the environment SHALL also reset memory, so no stale responses arrive.

Structure
REQ-032 Shared package ifu_pkg SHALL hold XLEN=32, the default RESET_PC, and the fetch_entry_t struct {pc, instr}.
REQ-033 Sub-module fetch_fifo SHALL be a parametrised synchronous FIFO of fetch_entry_t, DEPTH entries, with a clear input.

Verification
REQ-034 Reset release, mem_req_ready=1, 1-cycle memory, out_ready=1: requests to 0x80000000, 0x80000004, ...; out_pc sequence matches, one instruction per cycle after warm-up.
REQ-035 out_ready=0, DEPTH=4: exactly 4 requests are accepted, then mem_req_valid=0; releasing out_ready drains 4 entries in order.
REQ-036 Redirect to 0x80000100 with 3 requests in flight: those 3 responses are dropped; the next out_pc is 0x80000100; err stays 0.
REQ-037 Redirect coinciding with mem_rsp_valid and out_ready: the response is dropped, the FIFO is empty next cycle, and drop_cnt equals inflight-1.
REQ-038 fetch_pc=0xFFFFFFFC, then an accepted request: the next request address is 0x00000000.
REQ-039 mem_rsp_valid with no request outstanding: err rises next cycle and stays high until rst.

Source files
------------

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared instruction-fetch types, widths and reset address
package ifu_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
   localparam logic [XLEN-1:0] INSTR_BYTES      = 32'd4;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // Sequential fetch step; wraps modulo 2^XLEN.
   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
      return pc + INSTR_BYTES;
   endfunction

endpackage

// File: rtl/ifu_prefetch_if.sv
// rtl/ifu_prefetch_if.sv - memory, decode-side and redirect signals of the prefetcher
interface ifu_prefetch_if;
   import ifu_pkg::*;

   logic            mem_req_valid;
   logic            mem_req_ready;
   logic [XLEN-1:0] mem_req_addr;
   logic            mem_rsp_valid;
   logic [XLEN-1:0] mem_rsp_data;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_instr;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            err;

   modport master (
      output mem_req_valid, mem_req_addr,
      input  mem_req_ready,
      input  mem_rsp_valid, mem_rsp_data,
      output out_valid, out_pc, out_instr,
      input  out_ready,
      input  redirect, redirect_pc,
      output err
   );

   modport slave (
      input  mem_req_valid, mem_req_addr,
      output mem_req_ready,
      output mem_rsp_valid, mem_rsp_data,
      input  out_valid, out_pc, out_instr,
      output out_ready,
      output redirect, redirect_pc,
      input  err
   );

endinterface

// File: rtl/ifu_prefetch_fetch_fifo.sv
// rtl/ifu_prefetch_fetch_fifo.sv - synchronous FIFO of fetched {pc, instr} entries with flush
module fetch_fifo
   import ifu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear_i,
   input  logic                         push_i,
   input  fetch_entry_t                 push_data_i,
   input  logic                         pop_i,
   output fetch_entry_t                 head_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH):0]       count_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t    mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q;
   logic [PW-1:0]   rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic            do_push;
   logic            do_pop;

   assign do_push = push_i && (count_q != CW'(DEPTH));
   assign do_pop  = pop_i && (count_q != '0);

   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !clear_i && !rst) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - credit-limited sequential instruction prefetcher with redirect flush
module ifu_prefetch
   import ifu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int              DEPTH    = 4
) (
   input  logic           clk,
   input  logic           rst,
   ifu_prefetch_if.master bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]   inflight_q, inflight_d;
   logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
   logic            err_q, err_d;
   logic [CW-1:0]   occupancy;
   logic [CW:0]     credit_used;
   logic            req_fire, rsp_ack, rsp_stray;
   logic            push, pop, fifo_empty;
   fetch_entry_t    push_entry, head_entry;

   // Queued plus outstanding entries may never exceed the FIFO size, so pushes never overflow.
   assign credit_used        = {1'b0, occupancy} + {1'b0, inflight_q};
   assign bus.mem_req_valid  = !rst && !bus.redirect && (credit_used < (CW+1)'(DEPTH));
   assign bus.mem_req_addr   = fetch_pc_q;
   assign req_fire           = bus.mem_req_valid && bus.mem_req_ready;

   assign rsp_ack   = bus.mem_rsp_valid && (inflight_q != '0);
   assign rsp_stray = bus.mem_rsp_valid && (inflight_q == '0);
   assign push      = rsp_ack && (drop_cnt_q == '0) && !bus.redirect;
   assign pop       = bus.out_valid && bus.out_ready && !bus.redirect;
   assign push_entry = '{pc: rsp_pc_q, instr: bus.mem_rsp_data};

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      inflight_d = inflight_q;
      drop_cnt_d = drop_cnt_q;
      err_d      = err_q || rsp_stray;

      case ({req_fire, rsp_ack})
         2'b10:   inflight_d = inflight_q + 1'b1;
         2'b01:   inflight_d = inflight_q - 1'b1;
         default: inflight_d = inflight_q;
      endcase

      if (req_fire) fetch_pc_d = next_pc(fetch_pc_q);

      if (rsp_ack) begin
         if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - 1'b1;
         else                  rsp_pc_d   = next_pc(rsp_pc_q);
      end

      // Everything still outstanding after this cycle belongs to the old path.
      if (bus.redirect) begin
         fetch_pc_d = bus.redirect_pc;
         rsp_pc_d   = bus.redirect_pc;
         drop_cnt_d = inflight_q - CW'(rsp_ack);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         inflight_q <= '0;
         drop_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         inflight_q <= inflight_d;
         drop_cnt_q <= drop_cnt_d;
         err_q      <= err_d;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (bus.redirect),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .head_o      (head_entry),
      .empty_o     (fifo_empty),
      .count_o     (occupancy)
   );

   assign bus.out_valid = !rst && !fifo_empty;
   assign bus.out_pc    = head_entry.pc;
   assign bus.out_instr = head_entry.instr;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - randomized and directed bench for ifu_prefetch against an epoch-tagged fetch model
module tb_ifu_prefetch;

   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam int          DEPTH  = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ifu_prefetch_if bus();

   ifu_prefetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          rdy;
   } mreq_t;

   mreq_t       memq[$];
   logic [31:0] mfifo[$];
   logic [31:0] out_log[$];
   logic [31:0] req_log[$];
   logic [31:0] exp_fetch_pc;
   int          epoch, cyc, lat_lo, lat_hi;
   int          n_cmp, n_bad, n_acc_dut;
   bit          exp_err, inject_rsp;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic drive_mem();
      if (memq.size() != 0 && memq[0].rdy <= cyc) begin
         bus.mem_rsp_valid = 1'b1;
         bus.mem_rsp_data  = memf(memq[0].addr);
      end else if (inject_rsp) begin
         bus.mem_rsp_valid = 1'b1;
         bus.mem_rsp_data  = 32'hDEAD_BEEF;
      end else begin
         bus.mem_rsp_valid = 1'b0;
         bus.mem_rsp_data  = $urandom;
      end
   endtask

   // Evaluated mid-cycle: compare outputs, then apply this cycle's edge to the model.
   task automatic model_cycle();
      bit    exp_rv, exp_ov;
      mreq_t h;
      int    rdy;
      if (rst) begin
         check("rst_req_valid", bus.mem_req_valid, 0);
         check("rst_out_valid", bus.out_valid, 0);
         memq.delete();
         mfifo.delete();
         exp_fetch_pc = RST_PC;
         exp_err = 1'b0;
         epoch++;
         return;
      end
      exp_rv = !bus.redirect && (mfifo.size() + memq.size() < DEPTH);
      check("req_valid", bus.mem_req_valid, exp_rv);
      if (exp_rv) check("req_addr", bus.mem_req_addr, exp_fetch_pc);
      exp_ov = (mfifo.size() != 0);
      check("out_valid", bus.out_valid, exp_ov);
      if (exp_ov) begin
         check("out_pc", bus.out_pc, mfifo[0]);
         check("out_instr", bus.out_instr, memf(mfifo[0]));
      end
      check("err", bus.err, exp_err);

      if (bus.out_valid && bus.out_ready && !bus.redirect) out_log.push_back(bus.out_pc);
      if (bus.mem_req_valid && bus.mem_req_ready) begin
         req_log.push_back(bus.mem_req_addr);
         n_acc_dut++;
      end

      if (exp_ov && bus.out_ready && !bus.redirect) void'(mfifo.pop_front());
      if (bus.mem_rsp_valid) begin
         if (memq.size() == 0) exp_err = 1'b1;
         else begin
            h = memq.pop_front();
            if (h.epoch == epoch && !bus.redirect) mfifo.push_back(h.addr);
         end
      end
      if (bus.redirect) begin
         mfifo.delete();
         epoch++;
         exp_fetch_pc = bus.redirect_pc;
      end else if (exp_rv && bus.mem_req_ready) begin
         rdy = cyc + 1 + int'($urandom_range(lat_hi, lat_lo));
         memq.push_back('{addr: exp_fetch_pc, epoch: epoch, rdy: rdy});
         exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
      cyc++;
      drive_mem();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.redirect = 1'b0;
      inject_rsp = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      check("post_rst_err", bus.err, 0);
      check("post_rst_out_valid", bus.out_valid, 0);
      out_log.delete();
      req_log.delete();
      n_acc_dut = 0;
   endtask

   logic [31:0] tmp;
   int          exp_drop;
   bit          found;

   initial begin
      rst = 1'b1;
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
      bus.out_ready     = 1'b0;
      bus.redirect      = 1'b0;
      bus.redirect_pc   = '0;
      n_cmp = 0; n_bad = 0; cyc = 0; epoch = 0;
      lat_lo = 0; lat_hi = 0; inject_rsp = 1'b0;
      exp_fetch_pc = RST_PC; exp_err = 1'b0;

      // Streaming with a one-cycle memory: one instruction per cycle after two cycles of warm-up.
      do_reset();
      bus.mem_req_ready = 1'b1; bus.out_ready = 1'b1;
      repeat (30) step();
      check("stream_count", out_log.size(), 28);
      if (out_log.size() >= 3) check("stream_pc2", out_log[2], RST_PC + 32'd8);

      // Stalled decoder: credits stop requests at DEPTH, then the FIFO drains in order.
      do_reset();
      bus.out_ready = 1'b0;
      repeat (12) step();
      check("stall_accepted", n_acc_dut, DEPTH);
      check("stall_req_low", bus.mem_req_valid, 0);
      bus.out_ready = 1'b1;
      repeat (8) step();
      check("stall_drained", out_log.size() >= 4, 1);
      for (int i = 0; i < 4 && i < out_log.size(); i++)
         check("stall_order", out_log[i], RST_PC + 32'(4 * i));

      // Redirect with three requests in flight.
      do_reset();
      lat_lo = 6; lat_hi = 6;
      repeat (3) step();
      bus.mem_req_ready = 1'b0;
      bus.redirect = 1'b1; bus.redirect_pc = 32'h8000_0100;
      step();
      bus.redirect = 1'b0; bus.mem_req_ready = 1'b1; lat_lo = 0; lat_hi = 0;
      check("redir_drop_cnt", u_dut.drop_cnt_q, 3);
      out_log.delete();
      for (int i = 0; i < 40 && out_log.size() == 0; i++) step();
      check("redir_has_out", out_log.size() != 0, 1);
      if (out_log.size() != 0) check("redir_first_pc", out_log[0], 32'h8000_0100);
      check("redir_err", bus.err, 0);

      // Redirect in the same cycle as a response and a pop.
      do_reset();
      lat_lo = 2; lat_hi = 2;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         found = bus.mem_rsp_valid && bus.out_valid && memq.size() > 1;
      end
      check("coinc_setup", found, 1);
      exp_drop = memq.size() - 1;
      bus.redirect = 1'b1; bus.redirect_pc = 32'h8000_0200;
      step();
      bus.redirect = 1'b0;
      check("coinc_fifo_empty", bus.out_valid, 0);
      check("coinc_drop_cnt", u_dut.drop_cnt_q, exp_drop);
      repeat (15) step();

      // Fetch address wraps past the top of the address space.
      do_reset();
      lat_lo = 0; lat_hi = 0;
      bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
      step();
      bus.redirect = 1'b0;
      req_log.delete();
      repeat (4) step();
      check("wrap_count", req_log.size() >= 2, 1);
      if (req_log.size() >= 2) begin
         check("wrap_addr0", req_log[0], 32'hFFFF_FFFC);
         check("wrap_addr1", req_log[1], 32'h0000_0000);
      end

      // Stray response sets a sticky error that only reset clears.
      do_reset();
      bus.mem_req_ready = 1'b0;
      repeat (2) step();
      inject_rsp = 1'b1;
      drive_mem();
      inject_rsp = 1'b0;
      step();
      check("stray_err_rise", bus.err, 1);
      repeat (5) step();
      check("stray_err_sticky", bus.err, 1);
      check("stray_no_out", bus.out_valid, 0);
      bus.mem_req_ready = 1'b1;
      do_reset();
      check("stray_err_cleared", bus.err, 0);

      // Random traffic with redirects and occasional mid-run resets.
      lat_lo = 0; lat_hi = 3;
      for (int i = 0; i < 3000; i++) begin
         bus.mem_req_ready = ($urandom_range(3, 0) != 0);
         bus.out_ready     = ($urandom_range(3, 0) != 0);
         bus.redirect      = ($urandom_range(19, 0) == 0);
         tmp = $urandom;
         if ($urandom_range(3, 0) == 0) tmp = 32'hFFFF_FFF0 | (tmp & 32'hC);
         bus.redirect_pc   = tmp & ~32'h3;
         rst               = ($urandom_range(499, 0) == 0);
         step();
      end
      rst = 1'b0;
      bus.redirect = 1'b0;
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
